// File: rtl/exec_result_stage.sv
// Execute-stage back end: resolves control transfers and queues ALU results in a 2-entry
// skid buffer toward the memory stage. Define EXEC_STAGE_MISALIGN_EN for misaligned-target traps.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module exec_result_stage #(
    parameter int unsigned DATA_WIDTH     = `DATA_WIDTH,
    parameter int unsigned REG_ADDR_WIDTH = 5
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      flush_i,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [DATA_WIDTH-1:0]     alu_out,
    input  logic [DATA_WIDTH-1:0]     pc,
    input  logic [DATA_WIDTH-1:0]     imm,
    input  logic [DATA_WIDTH-1:0]     rs2_data,
    input  logic [REG_ADDR_WIDTH-1:0] rd_addr,
    input  logic                      is_branch,
    input  logic                      is_jal,
    input  logic                      is_jalr,
    input  logic                      mem_read,
    input  logic                      mem_write,
    input  logic                      reg_write,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DATA_WIDTH-1:0]     out_result,
    output logic [DATA_WIDTH-1:0]     out_addr,
    output logic [DATA_WIDTH-1:0]     out_store_data,
    output logic [REG_ADDR_WIDTH-1:0] out_rd,
    output logic                      out_mem_read,
    output logic                      out_mem_write,
    output logic                      out_reg_write,
    output logic                      redirect_valid,
    output logic [DATA_WIDTH-1:0]     redirect_pc,
    output logic                      misalign_exc
);

    localparam int unsigned EntW = 3 * DATA_WIDTH + REG_ADDR_WIDTH + 3;

    typedef enum logic [1:0] {
        StEmpty = 2'd0,
        StOne   = 2'd1,
        StTwo   = 2'd2
    } count_e;

    count_e                count_q, count_d;
    logic [EntW-1:0]       head_q, head_d;
    logic [EntW-1:0]       tail_q, tail_d;
    logic [EntW-1:0]       new_entry;
    logic                  in_fire, out_fire;
    logic                  taken, misaligned, redir_fire;
    logic [DATA_WIDTH-1:0] target, link_value, result;
    logic                  redirect_valid_q, redirect_valid_d;
    logic [DATA_WIDTH-1:0] redirect_pc_q, redirect_pc_d;

    // Handshake flags come from the count register only, so out_ready never reaches in_ready.
    assign in_ready  = (count_q != StTwo);
    assign out_valid = (count_q != StEmpty);
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;

    assign taken      = is_jal | is_jalr | (is_branch & alu_out[0]);
    assign target     = is_jalr ? (alu_out & ~{{(DATA_WIDTH-1){1'b0}}, 1'b1}) : (pc + imm);
    assign link_value = pc + {{(DATA_WIDTH-3){1'b0}}, 3'd4};
    assign result     = (is_jal | is_jalr) ? link_value : alu_out;

`ifdef EXEC_STAGE_MISALIGN_EN
    assign misaligned = taken & (target[1:0] != 2'b00);
`else
    assign misaligned = 1'b0;
`endif

    assign new_entry = {result, alu_out, rs2_data, rd_addr, mem_read, mem_write,
                        reg_write & ~misaligned};

    assign {out_result, out_addr, out_store_data, out_rd, out_mem_read, out_mem_write,
            out_reg_write} = head_q;

    always_comb begin
        count_d = count_q;
        head_d  = head_q;
        tail_d  = tail_q;
        if (flush_i) begin
            count_d = StEmpty;
        end else begin
            unique case (count_q)
                StEmpty: begin
                    if (in_fire) begin
                        head_d  = new_entry;
                        count_d = StOne;
                    end
                end
                StOne: begin
                    if (in_fire && out_fire) begin
                        head_d = new_entry;
                    end else if (in_fire) begin
                        tail_d  = new_entry;
                        count_d = StTwo;
                    end else if (out_fire) begin
                        count_d = StEmpty;
                    end
                end
                StTwo: begin
                    if (out_fire) begin
                        head_d  = tail_q;
                        count_d = StOne;
                    end
                end
                default: count_d = StEmpty;
            endcase
        end
    end

    // A flushed accept never redirects; a pulse already registered still emits.
    assign redir_fire       = in_fire & ~flush_i & taken;
    assign redirect_valid_d = redir_fire & ~misaligned;
    assign redirect_pc_d    = in_fire ? target : redirect_pc_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q          <= StEmpty;
            head_q           <= '0;
            tail_q           <= '0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
        end else begin
            count_q          <= count_d;
            head_q           <= head_d;
            tail_q           <= tail_d;
            redirect_valid_q <= redirect_valid_d;
            redirect_pc_q    <= redirect_pc_d;
        end
    end

    assign redirect_valid = redirect_valid_q;
    assign redirect_pc    = redirect_pc_q;

`ifdef EXEC_STAGE_MISALIGN_EN
    logic misalign_q, misalign_d;

    assign misalign_d = redir_fire & misaligned;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= misalign_d;
        end
    end

    assign misalign_exc = misalign_q;
`else
    assign misalign_exc = 1'b0;
`endif

endmodule

// File: tb/tb_exec_result_stage.sv
// Scoreboard bench for exec_result_stage: driver pushes expected entries/redirects into queues,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_exec_result_stage;

    localparam int DW = 32;
    localparam int RW = 5;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          flush_i = 1'b0, in_valid = 1'b0, in_ready;
    logic [DW-1:0] alu_out = '0, pc = '0, imm = '0, rs2_data = '0;
    logic [RW-1:0] rd_addr = '0;
    logic          is_branch = 1'b0, is_jal = 1'b0, is_jalr = 1'b0;
    logic          mem_read = 1'b0, mem_write = 1'b0, reg_write = 1'b0;
    logic          out_valid, out_ready = 1'b0;
    logic [DW-1:0] out_result, out_addr, out_store_data, redirect_pc;
    logic [RW-1:0] out_rd;
    logic          out_mem_read, out_mem_write, out_reg_write, redirect_valid, misalign_exc;

    always #5 clk = ~clk;

    exec_result_stage dut (
        .clk(clk), .rst_n(rst_n), .flush_i(flush_i), .in_valid(in_valid), .in_ready(in_ready),
        .alu_out(alu_out), .pc(pc), .imm(imm), .rs2_data(rs2_data), .rd_addr(rd_addr),
        .is_branch(is_branch), .is_jal(is_jal), .is_jalr(is_jalr), .mem_read(mem_read),
        .mem_write(mem_write), .reg_write(reg_write), .out_valid(out_valid),
        .out_ready(out_ready), .out_result(out_result), .out_addr(out_addr),
        .out_store_data(out_store_data), .out_rd(out_rd), .out_mem_read(out_mem_read),
        .out_mem_write(out_mem_write), .out_reg_write(out_reg_write),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .misalign_exc(misalign_exc)
    );

    typedef struct packed {
        logic [DW-1:0] result;
        logic [DW-1:0] addr;
        logic [DW-1:0] sdata;
        logic [RW-1:0] rd;
        logic          mr;
        logic          mw;
        logic          rw;
    } ent_t;

    typedef struct packed {
        logic          v;
        logic          m;
        logic [DW-1:0] pc;
    } red_t;

    ent_t exp_q[$];
    red_t red_q[$];
    int   checks = 0;
    int   errors = 0;
    bit   run = 1'b0;
    bit   pend_in = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // kind: 0 alu, 1 branch, 2 jal, 3 jalr, 4 load, 5 store
    task automatic cycle(input bit v, input bit f, input bit ordy, input int kind,
                         input logic [DW-1:0] a, input logic [DW-1:0] p,
                         input logic [DW-1:0] im, output bit fired);
        logic [DW-1:0] tgt;
        bit            tk, mis;
        ent_t          e;
        in_valid  = v;
        flush_i   = f;
        out_ready = ordy;
        alu_out   = a;
        pc        = p;
        imm       = im;
        rs2_data  = $urandom;
        rd_addr   = RW'($urandom);
        is_branch = (kind == 1);
        is_jal    = (kind == 2);
        is_jalr   = (kind == 3);
        mem_read  = (kind == 4);
        mem_write = (kind == 5);
        reg_write = !(kind == 1 || kind == 5);
        fired     = v && in_ready;
        tk  = (kind == 2) || (kind == 3) || (kind == 1 && a[0]);
        tgt = (kind == 3) ? {a[DW-1:1], 1'b0} : p + im;
`ifdef EXEC_STAGE_MISALIGN_EN
        mis = tk && (tgt[1:0] != 2'b00);
`else
        mis = 1'b0;
`endif
        e.result = (kind == 2 || kind == 3) ? p + 32'd4 : a;
        e.addr   = a;
        e.sdata  = rs2_data;
        e.rd     = rd_addr;
        e.mr     = mem_read;
        e.mw     = mem_write;
        e.rw     = reg_write && !mis;
        if (fired) exp_q.push_back(e);
        pend_in = fired;
        red_q.push_back('{v: fired && tk && !f && !mis, m: fired && tk && !f && mis, pc: tgt});
        @(posedge clk);
        #1;
        if (f) exp_q.delete();
    endtask

    task automatic push_until(input bit ordy, input int kind, input logic [DW-1:0] a,
                              input logic [DW-1:0] p, input logic [DW-1:0] im);
        bit fired = 1'b0;
        for (int i = 0; i < 10 && !fired; i++) cycle(1'b1, 1'b0, ordy, kind, a, p, im, fired);
        if (!fired) chk("accept_timeout", 64'd0, 64'd1);
    endtask

    always @(negedge clk) begin : monitor
        int   occ;
        ent_t e;
        red_t r;
        if (run) begin
            occ = exp_q.size() - (pend_in ? 1 : 0);
            chk("out_valid", 64'(out_valid), 64'(occ != 0));
            chk("in_ready", 64'(in_ready), 64'(occ != 2));
            if (out_valid && out_ready && occ > 0) begin
                e = exp_q.pop_front();
                chk("out_result", 64'(out_result), 64'(e.result));
                chk("out_addr", 64'(out_addr), 64'(e.addr));
                chk("out_store_data", 64'(out_store_data), 64'(e.sdata));
                chk("out_rd", 64'(out_rd), 64'(e.rd));
                chk("out_flags", 64'({out_mem_read, out_mem_write, out_reg_write}),
                    64'({e.mr, e.mw, e.rw}));
            end
            if (red_q.size() > 0) begin
                r = red_q.pop_front();
                chk("redirect_valid", 64'(redirect_valid), 64'(r.v));
                chk("misalign_exc", 64'(misalign_exc), 64'(r.m));
                if (r.v || r.m) chk("redirect_pc", 64'(redirect_pc), 64'(r.pc));
            end
        end
    end

    initial begin
        bit fired;
        #12;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_redirect", 64'(redirect_valid), 64'd0);
        chk("rst_misalign", 64'(misalign_exc), 64'd0);
        chk("rst_data", 64'({out_result, out_addr, out_store_data}), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        red_q.push_back('0);
        run = 1'b1;

        for (int i = 1; i <= 4; i++) cycle(1'b1, 1'b0, 1'b1, 0, DW'(i), 32'h0, 32'h0, fired);

        // Stall: two entries fill the buffer, third is held until space frees.
        cycle(1'b1, 1'b0, 1'b0, 0, 32'd5, 32'h0, 32'h0, fired);
        cycle(1'b1, 1'b0, 1'b0, 0, 32'd6, 32'h0, 32'h0, fired);
        cycle(1'b1, 1'b0, 1'b0, 0, 32'd7, 32'h0, 32'h0, fired);
        push_until(1'b1, 0, 32'd7, 32'h0, 32'h0);

        push_until(1'b1, 1, 32'd1, 32'h100, 32'h20);
        push_until(1'b1, 1, 32'd0, 32'h100, 32'h20);
        push_until(1'b1, 3, 32'h205, 32'h300, 32'h0);
        push_until(1'b1, 2, 32'h0, 32'h40, 32'h8);
        push_until(1'b1, 1, 32'd1, 32'h100, 32'h22);
        push_until(1'b1, 4, 32'h1000, 32'h0, 32'h0);
        push_until(1'b1, 5, 32'h1004, 32'h0, 32'h0);

        // Flush with a full buffer, then with a taken branch actually firing.
        cycle(1'b1, 1'b0, 1'b0, 0, 32'd8, 32'h0, 32'h0, fired);
        cycle(1'b1, 1'b0, 1'b0, 0, 32'd9, 32'h0, 32'h0, fired);
        cycle(1'b1, 1'b1, 1'b0, 2, 32'h0, 32'h80, 32'h10, fired);
        cycle(1'b1, 1'b0, 1'b0, 0, 32'd10, 32'h0, 32'h0, fired);
        cycle(1'b1, 1'b1, 1'b0, 1, 32'd1, 32'h200, 32'h40, fired);
        cycle(1'b0, 1'b0, 1'b1, 0, 32'h0, 32'h0, 32'h0, fired);

        for (int i = 0; i < 3000; i++) begin
            logic [DW-1:0] a, p, im;
            a  = ($urandom_range(0, 1) == 1) ? DW'($urandom_range(0, 15)) : $urandom;
            p  = $urandom & 32'hffff_fffc;
            im = $urandom & 32'hffff_fffe;
            cycle($urandom_range(0, 3) != 0, $urandom_range(0, 31) == 0,
                  $urandom_range(0, 2) != 0, $urandom_range(0, 5), a, p, im, fired);
        end

        for (int i = 0; i < 6; i++) cycle(1'b0, 1'b0, 1'b1, 0, 32'h0, 32'h0, 32'h0, fired);
        @(negedge clk);
        run = 1'b0;
        chk("drain_empty", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
